positadd_raw_pipe: RTL and testbench
====================================

POSITADD_RAW_PIPE -- requirements
Module: positadd_raw_pipe

Interface
REQ-001 SHALL have parameter FRAC_W, default 26: fraction bits of each input operand.
REQ-002 SHALL have parameter SCALE_W, default 9: signed scale (regime+exponent) bits of each input operand.
REQ-003 SHALL have derived widths IN_W=SCALE_W+FRAC_W+3, SFRAC_W=FRAC_W+4, OUT_W=SCALE_W+SFRAC_W+4; serialized format is {sgn, scale, fraction, inf, zero}, MSB first.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair present.
REQ-007 in_ready  output  1  block accepts the pair this cycle.
REQ-008 in1, in2  input  IN_W each  serialized raw operands.
REQ-009 sub  input  1  1 = compute in1-in2 (in2 sign inverted at capture), 0 = in1+in2.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  OUT_W  {sgn, scale[SCALE_W:0] signed, fraction[SFRAC_W-1:0], inf, zero}.
REQ-013 truncated  output  1  nonzero bits of the smaller operand were shifted out during alignment.

Function
REQ-014 SHALL be a 4-stage pipeline (capture/compare, align/add, leading-one detect/scale, normalize) with one valid bit per stage.
REQ-015 A transfer SHALL occur on in_valid&in_ready and on out_valid&out_ready; latency SHALL be exactly 4 cycles from input transfer to out_valid when out_ready stays high.
REQ-016 Each stage SHALL load when its successor is empty or transferring this cycle; in_ready SHALL be 1 whenever stage 0 is empty or advancing, so a full pipe sustains one result per cycle.
REQ-017 While out_valid=1 and out_ready=0, result and truncated SHALL hold stable; no transaction SHALL be dropped, duplicated or reordered.
REQ-018 An operand with zero=1 SHALL be treated as sgn=0, scale=0, fraction=0, inf=0, regardless of other bits.
REQ-019 Larger magnitude SHALL be chosen by scale, then fraction (tie -> in1); a zero operand is always the smaller.
REQ-020 The smaller significand {~zero, fraction} SHALL be right-shifted by the unsigned scale difference, saturating at 2*SFRAC_W (all bits shifted out).
REQ-021 Signs equal -> add significands; else subtract smaller from larger; the raw sum SHALL be SFRAC_W+1 bits.
REQ-022 Result scale SHALL be larger.scale+1 on carry, larger.scale-(leading-zero count) on cancellation, else larger.scale; result fraction SHALL be the sum left-justified with the hidden bit removed.
REQ-023 result.sgn SHALL equal the larger operand's sign, except 0 for an exact-cancellation zero.
REQ-024 result.zero SHALL be 1 on exact cancellation or both operands zero, and forced 0 when result.inf=1.
REQ-025 result.inf SHALL be the OR of both operand inf flags; sgn/scale/fraction are don't-care when inf=1.

Reset
REQ-026 While rst=1 all stage valid bits SHALL clear asynchronously: out_valid=0, in_ready=1, result=0, truncated=0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight transactions; after release the first accepted pair SHALL emerge after exactly 4 cycles.

Configuration
REQ-028 With POSITADD_RAW_STICKY_EN defined, result fraction bit 0 SHALL be ORed with the alignment-truncation flag (sticky for downstream rounding); truncated output still present.
REQ-029 Without POSITADD_RAW_STICKY_EN, result fraction bit 0 SHALL be the plain normalized sum bit.

Verification
REQ-030 in1=1.0 (scale 0, frac 0), in2=1.0, sub=0 -> 4 cycles later scale=1, fraction=0, sgn=0, zero=0, truncated=0.
REQ-031 in1=1.0, in2=1.0, sub=1 -> zero=1, sgn=0, inf=0.
REQ-032 in1=scale 0, in2=scale -40, frac 1 -> result scale 0, fraction=0, truncated=1; with sticky macro fraction bit 0=1.
REQ-033 in1 inf=1, in2=1.0 -> inf=1, zero=0.
REQ-034 6 back-to-back pairs, out_ready low cycles 5-7 -> in_ready drops once all stages full, all 6 results delivered in order, result stable while stalled.
REQ-035 rst pulsed with 3 transactions in flight -> out_valid=0 immediately, no stale result after release, next pair out after 4 cycles.

Source files
------------

// File: rtl/positadd_raw_pipe_if.sv
// positadd_raw_pipe_if: operand/result handshake bundle for the raw posit adder pipeline.
interface positadd_raw_pipe_if #(
  parameter int FRAC_W = 26,
  parameter int SCALE_W = 9
);
  localparam int IN_W = SCALE_W + FRAC_W + 3;
  localparam int OUT_W = SCALE_W + FRAC_W + 8;
  logic in_valid, in_ready, sub, out_valid, out_ready, truncated;
  logic [IN_W-1:0] in1, in2;
  logic [OUT_W-1:0] result;
  modport master(output in_valid, in1, in2, sub, out_ready, input in_ready, out_valid, result, truncated);
  modport slave(input in_valid, in1, in2, sub, out_ready, output in_ready, out_valid, result, truncated);
endinterface

// File: rtl/positadd_raw_pipe.sv
// positadd_raw_pipe: 4-stage raw posit adder (compare, align/add, LZD, normalize).
// POSITADD_RAW_STICKY_EN ORs the alignment-truncation flag into result fraction bit 0.
module positadd_raw_pipe #(
  parameter int FRAC_W = 26,
  parameter int SCALE_W = 9
) (
  input logic clk,
  input logic rst,
  positadd_raw_pipe_if.slave bus
);
  localparam int IN_W = SCALE_W + FRAC_W + 3;
  localparam int SFRAC_W = FRAC_W + 4;
  localparam int OUT_W = SCALE_W + SFRAC_W + 4;
  localparam int SC_W = SCALE_W + 1;
  localparam int SH_MAX = 2 * SFRAC_W;
  localparam int SH_W = $clog2(SH_MAX + 1);
  localparam int LZ_W = $clog2(SFRAC_W + 2);
  logic [3:0] v_q, en;
  logic z1, z2, s1, s2, swap;
  logic signed [SCALE_W-1:0] c1, c2;
  logic [FRAC_W-1:0] f1, f2;
  logic [SC_W-1:0] diff;
  logic sgn0_q, sub0_q, inf0_q;
  logic signed [SCALE_W-1:0] sc0_q;
  logic [SFRAC_W-1:0] lsig0_q, ssig0_q, shifted;
  logic [SH_W-1:0] sh0_q;
  logic [SFRAC_W:0] sum1, sum1_q, sum2_q;
  logic sgn1_q, inf1_q, tr1, tr1_q;
  logic signed [SCALE_W-1:0] sc1_q;
  logic [LZ_W-1:0] lz, lz2_q;
  logic [SC_W-1:0] sc2, sc2_q;
  logic sgn2_q, inf2_q, tr2_q, nz;
  logic [SFRAC_W-1:0] frac3;
  logic [OUT_W-1:0] res_q;
  logic tr_q;
  // a stage may load if it or any later stage is empty, or the consumer takes the head
  assign en = {~v_q[3], ~&v_q[3:2], ~&v_q[3:1], ~&v_q} | {4{bus.out_ready}};
  assign bus.in_ready = en[0];
  assign bus.out_valid = v_q[3];
  assign bus.result = res_q;
  assign bus.truncated = tr_q;
  always_comb begin
    z1 = bus.in1[0];
    z2 = bus.in2[0];
    s1 = bus.in1[IN_W-1] & ~z1;
    s2 = (bus.in2[IN_W-1] ^ bus.sub) & ~z2;
    c1 = z1 ? '0 : bus.in1[IN_W-2 -: SCALE_W];
    c2 = z2 ? '0 : bus.in2[IN_W-2 -: SCALE_W];
    f1 = z1 ? '0 : bus.in1[FRAC_W+1:2];
    f2 = z2 ? '0 : bus.in2[FRAC_W+1:2];
    swap = ~z2 & (z1 | c2 > c1 | (c2 == c1 & f2 > f1));
    diff = swap ? {c2[SCALE_W-1], c2} - {c1[SCALE_W-1], c1} : {c1[SCALE_W-1], c1} - {c2[SCALE_W-1], c2};
  end
  always_comb begin
    shifted = ssig0_q >> sh0_q;
    tr1 = (shifted << sh0_q) != ssig0_q;
    sum1 = sub0_q ? {1'b0, lsig0_q} - {1'b0, shifted} : {1'b0, lsig0_q} + {1'b0, shifted};
  end
  always_comb begin
    lz = LZ_W'(SFRAC_W + 1);
    for (int i = 0; i <= SFRAC_W; i++) if (sum1_q[i]) lz = LZ_W'(SFRAC_W - i);
    sc2 = sum1_q == '0 ? '0 : {sc1_q[SCALE_W-1], sc1_q} + SC_W'(1) - SC_W'(lz);
  end
  always_comb begin
    nz = |sum2_q;
`ifdef POSITADD_RAW_STICKY_EN
    frac3 = SFRAC_W'(sum2_q << lz2_q) | {{(SFRAC_W-1){1'b0}}, tr2_q};
`else
    frac3 = SFRAC_W'(sum2_q << lz2_q);
`endif
  end
  always_ff @(posedge clk) begin
    if (en[0]) begin
      sgn0_q <= swap ? s2 : s1;
      sc0_q <= swap ? c2 : c1;
      lsig0_q <= swap ? {~z2, f2, 3'b000} : {~z1, f1, 3'b000};
      ssig0_q <= swap ? {~z1, f1, 3'b000} : {~z2, f2, 3'b000};
      sh0_q <= diff > SC_W'(SH_MAX) ? SH_W'(SH_MAX) : diff[SH_W-1:0];
      sub0_q <= s1 ^ s2;
      inf0_q <= (bus.in1[1] & ~z1) | (bus.in2[1] & ~z2);
    end
    if (en[1]) begin
      sum1_q <= sum1;
      sgn1_q <= sgn0_q;
      sc1_q <= sc0_q;
      inf1_q <= inf0_q;
      tr1_q <= tr1;
    end
    if (en[2]) begin
      sum2_q <= sum1_q;
      lz2_q <= lz;
      sc2_q <= sc2;
      sgn2_q <= sgn1_q;
      inf2_q <= inf1_q;
      tr2_q <= tr1_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      res_q <= '0;
      tr_q <= 1'b0;
    end else begin
      v_q <= (en & {v_q[2:0], bus.in_valid}) | (~en & v_q);
      if (en[3]) begin
        res_q <= {sgn2_q & nz, sc2_q, frac3, inf2_q, ~nz & ~inf2_q};
        tr_q <= tr2_q;
      end
    end
  end
endmodule

// File: tb/tb_positadd_raw_pipe.sv
// tb_positadd_raw_pipe: directed checks of the raw posit adder pipeline.
module tb_positadd_raw_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_run = 0;
  int n_fail = 0;
`ifdef POSITADD_RAW_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif
  positadd_raw_pipe_if #(.FRAC_W(26), .SCALE_W(9)) bus ();
  positadd_raw_pipe #(.FRAC_W(26), .SCALE_W(9)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [37:0] mk(input logic s, input logic signed [8:0] c, input logic [25:0] f, input logic inf, input logic z);
    return {s, c, f, inf, z};
  endfunction

  function automatic logic [42:0] er(input logic s, input logic signed [9:0] c, input logic [29:0] f, input logic inf, input logic z);
    return {s, c, f, inf, z};
  endfunction

  task automatic run_op(input logic [37:0] a, input logic [37:0] b, input logic sb, output logic [42:0] res, output logic tr, output int lat);
    bus.in_valid = 1'b1;
    bus.in1 = a;
    bus.in2 = b;
    bus.sub = sb;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    tr = bus.truncated;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_run++; if (bus.result !== 43'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.result); end
    n_run++; if (bus.truncated !== 1'b0) begin n_fail++; $display("FAIL reset_truncated got %b want 0", bus.truncated); end
  endtask

  task automatic test_arith;
    logic [37:0] ta [9];
    logic [37:0] tb2 [9];
    logic ts [9];
    logic [42:0] te [9];
    logic tt [9];
    logic [42:0] res;
    logic tr;
    int lat;
    ta[0] = mk(0, 0, 0, 0, 0);            tb2[0] = mk(0, 0, 0, 0, 0);            ts[0] = 0; te[0] = er(0, 1, 0, 0, 0); tt[0] = 0;
    ta[1] = mk(0, 0, 26'h2000000, 0, 0);  tb2[1] = mk(0, -9'sd2, 0, 0, 0);       ts[1] = 0; te[1] = er(0, 0, 30'h30000000, 0, 0); tt[1] = 0;
    ta[2] = mk(0, 0, 26'h2000000, 0, 0);  tb2[2] = mk(0, 0, 26'h1000000, 0, 0);  ts[2] = 1; te[2] = er(0, -10'sd2, 0, 0, 0); tt[2] = 0;
    ta[3] = mk(0, 0, 0, 0, 0);            tb2[3] = mk(1, 1, 0, 0, 0);            ts[3] = 0; te[3] = er(1, 0, 0, 0, 0); tt[3] = 0;
    ta[4] = mk(0, 0, 0, 0, 0);            tb2[4] = mk(1, 0, 0, 0, 0);            ts[4] = 1; te[4] = er(0, 1, 0, 0, 0); tt[4] = 0;
    ta[5] = mk(1, 7, 26'h155, 0, 1);      tb2[5] = mk(1, -9'sd5, 0, 0, 0);       ts[5] = 0; te[5] = er(1, -10'sd5, 0, 0, 0); tt[5] = 0;
    ta[6] = mk(0, 0, 0, 0, 0);            tb2[6] = mk(0, -9'sd29, 0, 0, 0);      ts[6] = 0; te[6] = er(0, 0, 30'd2, 0, 0); tt[6] = 0;
    ta[7] = mk(0, 0, 0, 0, 0);            tb2[7] = mk(0, -9'sd30, 0, 0, 0);      ts[7] = 0; te[7] = er(0, 0, {29'd0, STK}, 0, 0); tt[7] = 1;
    ta[8] = mk(0, 0, 0, 0, 0);            tb2[8] = mk(0, -9'sd40, 26'd1, 0, 0);  ts[8] = 0; te[8] = er(0, 0, {29'd0, STK}, 0, 0); tt[8] = 1;
    for (int i = 0; i < 9; i++) begin
      run_op(ta[i], tb2[i], ts[i], res, tr, lat);
      n_run++; if (lat !== 4) begin n_fail++; $display("FAIL arith%0d_latency got %0d want 4", i, lat); end
      n_run++; if (res !== te[i]) begin n_fail++; $display("FAIL arith%0d_result got %h want %h", i, res, te[i]); end
      n_run++; if (tr !== tt[i]) begin n_fail++; $display("FAIL arith%0d_truncated got %b want %b", i, tr, tt[i]); end
    end
  endtask

  task automatic test_special;
    logic [42:0] res;
    logic tr;
    int lat;
    run_op(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), 1'b1, res, tr, lat);
    n_run++; if ({res[42], res[1], res[0], tr} !== 4'b0010) begin n_fail++; $display("FAIL cancel_sgn_inf_zero_tr got %b want 0010", {res[42], res[1], res[0], tr}); end
    n_run++; if (lat !== 4) begin n_fail++; $display("FAIL cancel_latency got %0d want 4", lat); end
    run_op(mk(0, 0, 0, 0, 1), mk(1, 3, 26'd5, 0, 1), 1'b0, res, tr, lat);
    n_run++; if ({res[42], res[1], res[0]} !== 3'b001) begin n_fail++; $display("FAIL both_zero_sgn_inf_zero got %b want 001", {res[42], res[1], res[0]}); end
    run_op(mk(0, 0, 0, 1, 0), mk(0, 0, 0, 0, 0), 1'b0, res, tr, lat);
    n_run++; if (res[1:0] !== 2'b10) begin n_fail++; $display("FAIL inf_in1 got %b want 10", res[1:0]); end
    run_op(mk(0, 0, 0, 0, 1), mk(0, 2, 0, 1, 0), 1'b1, res, tr, lat);
    n_run++; if (res[1:0] !== 2'b10) begin n_fail++; $display("FAIL inf_in2_zero_in1 got %b want 10", res[1:0]); end
  endtask

  task automatic test_back_to_back;
    logic [42:0] held;
    logic stalled, saw_nr, xfer;
    int idx, got;
    idx = 0; got = 0; stalled = 0; saw_nr = 0; held = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      bus.in_valid = idx < 6;
      bus.in1 = mk(0, 9'(idx), 0, 0, 0);
      bus.in2 = mk(0, 9'(idx), 0, 0, 0);
      bus.sub = 1'b0;
      bus.out_ready = !(cyc >= 5 && cyc <= 7);
      @(negedge clk);
      if (bus.in_valid && !bus.in_ready) saw_nr = 1;
      if (stalled) begin
        n_run++; if (bus.out_valid !== 1'b1 || bus.result !== held) begin n_fail++; $display("FAIL stall_hold got v=%b %h want v=1 %h", bus.out_valid, bus.result, held); end
      end
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready) begin
          n_run++; if (bus.result !== er(0, 10'(got + 1), 0, 0, 0)) begin n_fail++; $display("FAIL b2b_result%0d got %h want %h", got, bus.result, er(0, 10'(got + 1), 0, 0, 0)); end
          got++;
          stalled = 0;
        end else begin
          held = bus.result;
          stalled = 1;
        end
      end
      xfer = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (xfer) idx++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n_run++; if (got !== 6) begin n_fail++; $display("FAIL b2b_count got %0d want 6", got); end
    n_run++; if (saw_nr !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_drop got %b want 1", saw_nr); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_flight;
    logic [42:0] res;
    logic tr;
    int lat, stale;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in1 = mk(0, 9'(k + 3), 0, 0, 0);
      bus.in2 = mk(0, 9'(k + 3), 0, 0, 0);
      bus.sub = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_run++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flight_head_valid got %b want 1", bus.out_valid); end
    #2 rst = 1'b1;
    #1;
    n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flight_rst_out_valid got %b want 0", bus.out_valid); end
    n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flight_rst_in_ready got %b want 1", bus.in_ready); end
    n_run++; if (bus.result !== 43'd0) begin n_fail++; $display("FAIL flight_rst_result got %h want 0", bus.result); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) stale++;
    end
    n_run++; if (stale !== 0) begin n_fail++; $display("FAIL flight_stale got %0d want 0", stale); end
    run_op(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), 1'b0, res, tr, lat);
    n_run++; if (lat !== 4) begin n_fail++; $display("FAIL flight_after_latency got %0d want 4", lat); end
    n_run++; if (res !== er(0, 1, 0, 0, 0)) begin n_fail++; $display("FAIL flight_after_result got %h want %h", res, er(0, 1, 0, 0, 0)); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    test_reset;
    @(posedge clk); #1;
    rst = 1'b0;
    test_arith;
    test_special;
    test_back_to_back;
    test_reset_flight;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
